// File: rtl/io_unit.sv
// Port I/O and interrupt controller: external port access, IMASK/IPEND registers,
// a saved return address, and vectored interrupt acknowledge over a shared tristate bus.
module io_unit #(
    parameter logic [15:0] VEC_BASE = 16'hFFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_addr_read,
    input  logic [3:0]  io_addr,
    input  logic        io_read,
    input  logic        io_push,
    input  logic        io_write,
    input  logic        io_store_retaddr,
    input  logic        io_push_retaddr,
    input  logic        io_push_ints,
    input  logic        io_push_int_addr,
    output logic        io_interrupt,
    inout  wire  [15:0] d_bus,
    input  logic [15:0] irq,
    output logic [3:0]  dev_addr,
    output logic        dev_re,
    output logic        dev_we,
    output logic [15:0] dev_wdata,
    input  logic [15:0] dev_rdata
);

    localparam logic [3:0] ADDR_IMASK = 4'd14;
    localparam logic [3:0] ADDR_IPEND = 4'd15;

    logic [15:0] ipend;
    logic [15:0] imask;
    logic [15:0] retaddr;
    logic [15:0] rdata;

    logic [15:0] sync_meta;
    logic [15:0] sync_stable;
    logic [15:0] sync_q;
    logic [15:0] sync_qq;
    logic [3:0]  prime;

    logic        rd_access;
    logic        wr_access;
    logic        ext_port;
    logic [15:0] masked;
    logic        int_any;
    logic [3:0]  int_index;
    logic [15:0] int_onehot;
    logic [15:0] int_addr;
    logic [15:0] irq_edge;
    logic [15:0] ack_clear;
    logic [15:0] w1c_clear;
    logic [15:0] ipend_next;
    logic        bus_en;
    logic [15:0] bus_val;

    assign rd_access = io_read & io_addr_read;
    assign wr_access = io_write & io_addr_read;
    assign ext_port  = (io_addr < ADDR_IMASK);

    assign dev_addr  = io_addr;
    assign dev_re    = rd_access & ext_port;
    assign dev_we    = wr_access & ext_port;
    assign dev_wdata = d_bus;

    // Edges only count once sync_qq holds a real post-reset sample, so a line
    // that was already high when reset released never looks like a rising edge.
    assign irq_edge = sync_q & ~sync_qq & {16{prime[3]}};

    assign masked  = ipend & imask;
    assign int_any = |masked;

    always_comb begin
        int_index = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (masked[i]) begin
                int_index = 4'(i);
            end
        end
    end

    assign int_onehot = int_any ? (16'd1 << int_index) : 16'd0;
    assign int_addr   = VEC_BASE + {12'd0, int_index};

    assign ack_clear  = io_push_int_addr ? int_onehot : 16'd0;
    assign w1c_clear  = (wr_access && io_addr == ADDR_IPEND) ? d_bus : 16'd0;
    assign ipend_next = (ipend & ~(ack_clear | w1c_clear)) | irq_edge;

    always_comb begin
        bus_en  = 1'b1;
        bus_val = 16'd0;
        if (io_push_int_addr) begin
            bus_val = int_addr;
        end else if (io_push_retaddr) begin
            bus_val = retaddr;
        end else if (io_push_ints) begin
            bus_val = ipend;
        end else if (io_push) begin
            bus_val = rdata;
        end else begin
            bus_en = 1'b0;
        end
    end

    assign d_bus = bus_en ? bus_val : 16'hzzzz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta   <= 16'd0;
            sync_stable <= 16'd0;
            sync_q      <= 16'd0;
            sync_qq     <= 16'd0;
            prime       <= 4'd0;
        end else begin
            sync_meta   <= irq;
            sync_stable <= sync_meta;
            sync_q      <= sync_stable;
            sync_qq     <= sync_q;
            prime       <= {prime[2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ipend        <= 16'd0;
            imask        <= 16'hFFFF;
            retaddr      <= 16'd0;
            rdata        <= 16'd0;
            io_interrupt <= 1'b0;
        end else begin
            ipend        <= ipend_next;
            io_interrupt <= int_any;
            if (wr_access && io_addr == ADDR_IMASK) begin
                imask <= d_bus;
            end
            if (io_store_retaddr) begin
                retaddr <= d_bus;
            end
            if (rd_access) begin
                case (io_addr)
                    ADDR_IMASK: rdata <= imask;
                    ADDR_IPEND: rdata <= ipend;
                    default:    rdata <= dev_rdata;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_io_unit.sv
// Directed bench for io_unit: a vector table for port access plus hand-written
// sequences for interrupt timing, priority, set-beats-clear and reset behaviour.
module tb_io_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_addr_read;
    logic [3:0]  io_addr;
    logic        io_read;
    logic        io_push;
    logic        io_write;
    logic        io_store_retaddr;
    logic        io_push_retaddr;
    logic        io_push_ints;
    logic        io_push_int_addr;
    logic        io_interrupt;
    logic [15:0] irq;
    logic [3:0]  dev_addr;
    logic        dev_re;
    logic        dev_we;
    logic [15:0] dev_wdata;
    logic [15:0] dev_rdata;
    logic        tb_drv;
    logic [15:0] tb_val;
    tri   [15:0] d_bus;

    int errors = 0;
    int checks = 0;

    assign d_bus = tb_drv ? tb_val : 16'hzzzz;

    always #5 clk = ~clk;

    io_unit #(.VEC_BASE(16'hFFF0)) dut (
        .clk              (clk),
        .rst              (rst),
        .io_addr_read     (io_addr_read),
        .io_addr          (io_addr),
        .io_read          (io_read),
        .io_push          (io_push),
        .io_write         (io_write),
        .io_store_retaddr (io_store_retaddr),
        .io_push_retaddr  (io_push_retaddr),
        .io_push_ints     (io_push_ints),
        .io_push_int_addr (io_push_int_addr),
        .io_interrupt     (io_interrupt),
        .d_bus            (d_bus),
        .irq              (irq),
        .dev_addr         (dev_addr),
        .dev_re           (dev_re),
        .dev_we           (dev_we),
        .dev_wdata        (dev_wdata),
        .dev_rdata        (dev_rdata)
    );

    typedef struct packed {
        logic        ar;
        logic [3:0]  addr;
        logic        rd;
        logic        wr;
        logic        push;
        logic        drv;
        logic [15:0] dval;
        logic [15:0] rdata;
        logic        exp_re;
        logic        exp_we;
        logic        chk_bus;
        logic [15:0] exp_bus;
    } vec_t;

    vec_t vecs [17];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic idle();
        io_addr_read     = 1'b0;
        io_addr          = 4'd0;
        io_read          = 1'b0;
        io_push          = 1'b0;
        io_write         = 1'b0;
        io_store_retaddr = 1'b0;
        io_push_retaddr  = 1'b0;
        io_push_ints     = 1'b0;
        io_push_int_addr = 1'b0;
        tb_drv           = 1'b0;
        tb_val           = 16'd0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        idle();
        io_addr_read = v.ar;
        io_addr      = v.addr;
        io_read      = v.rd;
        io_write     = v.wr;
        io_push      = v.push;
        tb_drv       = v.drv;
        tb_val       = v.dval;
        dev_rdata    = v.rdata;
        #2;
    endtask

    task automatic writeReg(input logic [3:0] addr, input logic [15:0] val);
        @(negedge clk);
        idle();
        io_addr_read = 1'b1;
        io_addr      = addr;
        io_write     = 1'b1;
        tb_drv       = 1'b1;
        tb_val       = val;
        @(negedge clk);
        idle();
    endtask

    task automatic peekIpend(input string name, input logic [15:0] expected);
        io_push_ints = 1'b1;
        #1;
        checkOutput(name, d_bus, expected);
        io_push_ints = 1'b0;
        #1;
    endtask

    initial begin
        // ar, addr, rd, wr, push, drv, dval, rdata, exp_re, exp_we, chk_bus, exp_bus
        vecs[0]  = '{1'b1, 4'd4,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hA5A5, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 4'd4,  1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1111, 1'b0, 1'b0, 1'b1, 16'hA5A5};
        vecs[2]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h2222, 1'b0, 1'b0, 1'b1, 16'hA5A5};
        vecs[3]  = '{1'b1, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h3333, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFF};
        vecs[5]  = '{1'b1, 4'd14, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00F0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[6]  = '{1'b1, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00F0};
        vecs[8]  = '{1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 4'd14, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[10] = '{1'b1, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00F0};
        vecs[12] = '{1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h7777, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[13] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
        vecs[14] = '{1'b1, 4'd13, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[15] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h5A5A};
        vecs[16] = '{1'b1, 4'd14, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};

        idle();
        irq       = 16'd0;
        dev_rdata = 16'd0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_int", {15'd0, io_interrupt}, 16'd0);
        rst = 1'b0;

        // Reset values seen through the bus
        @(negedge clk);
        io_push = 1'b1;
        #1;
        checkOutput("rst_rdata", d_bus, 16'h0000);
        io_push = 1'b0;
        io_push_retaddr = 1'b1;
        #1;
        checkOutput("rst_retaddr", d_bus, 16'h0000);
        io_push_retaddr = 1'b0;
        peekIpend("rst_ipend", 16'h0000);
        repeat (6) @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_dev_re", i), {15'd0, dev_re}, {15'd0, vecs[i].exp_re});
            checkOutput($sformatf("v%0d_dev_we", i), {15'd0, dev_we}, {15'd0, vecs[i].exp_we});
            checkOutput($sformatf("v%0d_dev_addr", i), {12'd0, dev_addr}, {12'd0, vecs[i].addr});
            if (vecs[i].drv) begin
                checkOutput($sformatf("v%0d_dev_wdata", i), dev_wdata, vecs[i].dval);
            end
            if (vecs[i].chk_bus) begin
                checkOutput($sformatf("v%0d_bus", i), d_bus, vecs[i].exp_bus);
            end
        end
        @(negedge clk);
        idle();

        // irq[3] rise: IPEND after four edges, io_interrupt one edge later
        irq[3] = 1'b1;
        repeat (3) @(negedge clk);
        peekIpend("irq3_e3", 16'h0000);
        @(negedge clk);
        peekIpend("irq3_e4", 16'h0008);
        checkOutput("int_e4", {15'd0, io_interrupt}, 16'd0);
        @(negedge clk);
        #1;
        checkOutput("int_e5", {15'd0, io_interrupt}, 16'd1);
        io_push_int_addr = 1'b1;
        #1;
        checkOutput("vec_irq3", d_bus, 16'hFFF3);
        @(negedge clk);
        io_push_int_addr = 1'b0;
        peekIpend("ack_irq3", 16'h0000);
        @(negedge clk);
        #1;
        checkOutput("int_after_ack", {15'd0, io_interrupt}, 16'd0);
        irq[3] = 1'b0;

        // Two sources with bit 1 masked, then unmasked
        writeReg(4'd14, 16'hFFFD);
        irq[1] = 1'b1;
        irq[5] = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        checkOutput("int_two", {15'd0, io_interrupt}, 16'd1);
        io_push_int_addr = 1'b1;
        #1;
        checkOutput("vec_irq5", d_bus, 16'hFFF5);
        @(negedge clk);
        io_push_int_addr = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("masked_no_int", {15'd0, io_interrupt}, 16'd0);
        peekIpend("masked_pending", 16'h0002);
        writeReg(4'd14, 16'hFFFF);
        @(negedge clk);
        #1;
        checkOutput("unmask_int", {15'd0, io_interrupt}, 16'd1);
        io_push_int_addr = 1'b1;
        #1;
        checkOutput("vec_irq1", d_bus, 16'hFFF1);
        @(negedge clk);
        #1;
        checkOutput("vec_none", d_bus, 16'hFFF0);
        @(negedge clk);
        io_push_int_addr = 1'b0;
        peekIpend("none_cleared", 16'h0000);
        irq[1] = 1'b0;
        irq[5] = 1'b0;

        // Return address capture and bus drive priority
        @(negedge clk);
        tb_drv = 1'b1;
        tb_val = 16'h0123;
        io_store_retaddr = 1'b1;
        @(negedge clk);
        idle();
        io_push_retaddr = 1'b1;
        io_push_ints    = 1'b1;
        io_push         = 1'b1;
        #1;
        checkOutput("prio_retaddr", d_bus, 16'h0123);
        io_push_int_addr = 1'b1;
        #1;
        checkOutput("prio_int_addr", d_bus, 16'hFFF0);
        io_push_int_addr = 1'b0;
        io_push_retaddr  = 1'b0;
        #1;
        checkOutput("prio_ints", d_bus, 16'h0000);
        io_push_ints = 1'b0;
        #1;
        checkOutput("push_only", d_bus, 16'h5A5A);
        io_push = 1'b0;

        // Write-1-to-clear affects only the selected bit
        irq[0] = 1'b1;
        irq[3] = 1'b1;
        repeat (6) @(negedge clk);
        peekIpend("two_pending", 16'h0009);
        writeReg(4'd15, 16'h0008);
        peekIpend("w1c_bit3", 16'h0001);
        io_push_int_addr = 1'b1;
        #1;
        checkOutput("vec_irq0", d_bus, 16'hFFF0);
        @(negedge clk);
        io_push_int_addr = 1'b0;
        peekIpend("ack_irq0", 16'h0000);
        irq[0] = 1'b0;
        irq[3] = 1'b0;

        // Set beats clear on the same edge
        irq[2] = 1'b1;
        repeat (6) @(negedge clk);
        irq[2] = 1'b0;
        repeat (6) @(negedge clk);
        irq[2] = 1'b1;
        repeat (3) @(negedge clk);
        io_addr_read = 1'b1;
        io_addr      = 4'd15;
        io_write     = 1'b1;
        tb_drv       = 1'b1;
        tb_val       = 16'h0004;
        @(negedge clk);
        idle();
        peekIpend("set_beats_clear", 16'h0004);

        // Asynchronous reset in the middle of an access
        writeReg(4'd14, 16'h0004);
        irq[7] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("pre_rst_int", {15'd0, io_interrupt}, 16'd1);
        @(negedge clk);
        io_addr_read = 1'b1;
        io_addr      = 4'd5;
        io_read      = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_int", {15'd0, io_interrupt}, 16'd0);
        checkOutput("arst_dev_re", {15'd0, dev_re}, 16'd1);
        io_push_retaddr = 1'b1;
        #1;
        checkOutput("arst_retaddr", d_bus, 16'h0000);
        io_push_retaddr = 1'b0;
        io_push = 1'b1;
        #1;
        checkOutput("arst_rdata", d_bus, 16'h0000);
        io_push = 1'b0;
        peekIpend("arst_ipend", 16'h0000);
        @(negedge clk);
        idle();
        rst = 1'b0;
        @(negedge clk);
        io_addr_read = 1'b1;
        io_addr      = 4'd14;
        io_read      = 1'b1;
        @(negedge clk);
        idle();
        io_push = 1'b1;
        #1;
        checkOutput("arst_imask", d_bus, 16'hFFFF);
        io_push = 1'b0;

        // Lines held high through reset release must not register an edge
        repeat (8) @(negedge clk);
        peekIpend("held_high_no_edge", 16'h0000);
        irq[7] = 1'b0;
        repeat (6) @(negedge clk);
        irq[7] = 1'b1;
        repeat (6) @(negedge clk);
        peekIpend("edge_after_reset", 16'h0080);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_unit.md
IO_UNIT -- requirements
Module: io_unit

Interface
REQ-001 Parameter VEC_BASE, default 16'hFFF0: base memory address of the 16-entry interrupt vector table.
REQ-002 clk  in  1  system clock; all state updates on posedge.
REQ-003 rst  in  1  reset; one clock, asynchronous, active-high.
REQ-004 io_addr_read  in  1  qualifies io_read/io_write; an access with io_addr_read=0 is ignored.
REQ-005 io_addr  in  4  port address: 0-13 external, 14 = IMASK, 15 = IPEND.
REQ-006 io_read  in  1  port read request; data is captured on this edge.
REQ-007 io_push  in  1  drive captured read data onto d_bus.
REQ-008 io_write  in  1  port write; data taken from d_bus.
REQ-009 io_store_retaddr  in  1  capture d_bus into RETADDR.
REQ-010 io_push_retaddr  in  1  drive RETADDR onto d_bus.
REQ-011 io_push_ints  in  1  drive IPEND onto d_bus.
REQ-012 io_push_int_addr  in  1  drive vector address onto d_bus and acknowledge that interrupt.
REQ-013 io_interrupt  out  1  registered: any unmasked pending interrupt.
REQ-014 d_bus  inout  16  shared data bus; high-Z unless a push strobe is active.
REQ-015 irq  in  16  asynchronous device interrupt lines, rising-edge sensitive.
REQ-016 dev_addr  out  4  combinational copy of io_addr.
REQ-017 dev_re  out  1  combinational: io_read & io_addr_read & io_addr<14.
REQ-018 dev_we  out  1  combinational: io_write & io_addr_read & io_addr<14.
REQ-019 dev_wdata  out  16  combinational copy of d_bus.
REQ-020 dev_rdata  in  16  device read data; valid in the same cycle dev_re is high.

Function
REQ-021 Each irq bit SHALL pass a 2-flop synchronizer, then a rising-edge detector (sync_q & ~sync_qq); an edge sets the matching IPEND bit.
REQ-022 Read capture: on posedge with io_read & io_addr_read, RDATA SHALL load dev_rdata (addr 0-13), IMASK (14), or IPEND (15).
REQ-023 io_push=1 SHALL drive RDATA on d_bus in that cycle; latency is exactly one cycle from io_read to io_push.
REQ-024 Write: io_write & io_addr_read at addr 14 SHALL load IMASK <= d_bus; at addr 15 SHALL clear every IPEND bit whose d_bus bit is 1 (write-1-to-clear).
REQ-025 io_interrupt SHALL be registered as |(IPEND & IMASK), i.e. it updates one cycle after IPEND/IMASK change.
REQ-026 Selected interrupt index SHALL be the lowest-numbered set bit of IPEND & IMASK.
REQ-027 io_push_int_addr SHALL drive VEC_BASE + index (16-bit, wrap modulo 2^16) and clear that IPEND bit at the posedge ending the cycle.
REQ-028 io_push_int_addr with no unmasked pending bit SHALL drive VEC_BASE and clear nothing.
REQ-029 io_store_retaddr SHALL load RETADDR <= d_bus at posedge; io_push_retaddr SHALL drive RETADDR.
REQ-030 io_push_ints SHALL drive IPEND (unmasked and masked bits).
REQ-031 d_bus drive priority if strobes overlap: io_push_int_addr > io_push_retaddr > io_push_ints > io_push; exactly one source driven.
REQ-032 Same cycle io_store_retaddr and io_push_int_addr: the block is not driving during capture except by the int_addr source; RETADDR SHALL capture the externally driven PC, with the int-address push deferred by the caller's bus timing (both strobes legal together; capture takes d_bus as resolved).
REQ-033 Set beats clear: an irq edge on a bit cleared in the same cycle (ack or W1C) SHALL leave the bit set.
REQ-034 Masked pending bits SHALL stay pending and raise io_interrupt once unmasked.

Reset
REQ-035 On rst: IPEND=0, IMASK=16'hFFFF, RETADDR=0, RDATA=0, synchronizer flops=0, io_interrupt=0, d_bus high-Z.
REQ-036 Reset mid-access SHALL abort it; no IMASK/IPEND write, no pending clear; dev_re/dev_we follow inputs combinationally.
REQ-037 Edges on irq lines held high through reset deassertion SHALL NOT set IPEND (synchronizer reset to 0, first high sample after reset counts as an edge only if preceded by a low sample).

Verification
REQ-038 irq[3] 0->1 -> IPEND[3]=1 four edges later, io_interrupt=1 on the next; io_push_int_addr -> d_bus=16'hFFF3, IPEND[3]=0, io_interrupt=0 one cycle later.
REQ-039 irq[1] and irq[5] rise together, IMASK=16'hFFFD -> io_push_int_addr yields 16'hFFF5; IMASK<=16'hFFFF then yields 16'hFFF1.
REQ-040 io_read addr 4, dev_rdata=16'hA5A5; next cycle io_push -> d_bus=16'hA5A5; io_addr_read=0 -> dev_re=0, RDATA unchanged.
REQ-041 io_store_retaddr with d_bus=16'h0123, later io_push_retaddr -> d_bus=16'h0123; write 16'h0008 to addr 15 clears IPEND[3] only.
REQ-042 irq[2] edge same cycle as W1C of bit 2 -> IPEND[2]=1; rst asserted mid-sequence -> all registers at REQ-035 values asynchronously.
